// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera capture path: FSM states,
// pixel/word widths and the sideband layout of buffered words.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    CAPTURE    = 2'd2,
    DROP_FRAME = 2'd3
  } cap_state_t;

  localparam int unsigned PIXEL_W = 16;
  localparam int unsigned WORD_W  = 2 * PIXEL_W;
  localparam int unsigned ENTRY_W = WORD_W + 2;
  localparam int unsigned SOF_BIT = 33;
  localparam int unsigned EOL_BIT = 32;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic sof,
                                                    input logic eol,
                                                    input logic [WORD_W-1:0] word);
    return {sof, eol, word};
  endfunction

endpackage

// File: rtl/pixel_word_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is presented
// combinationally and reads as zero while the FIFO is empty.
module pixel_word_fifo
  import cam_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is still accepted when the head leaves this cycle.
  always_comb begin
    full  = (count == FULL_COUNT);
    empty = (count == '0);
    do_rd = rd_en && !empty;
    do_wr = wr_en && (!full || do_rd);
    rd_data = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cam_pixel_packer.sv
// Captures RGB565 bytes from a VSYNC/HREF camera bus, packs two pixels per
// 32-bit word with frame/line sideband, and buffers words for the consumer.
module cam_pixel_packer
  import cam_capture_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        v_sync,
  input  logic        h_ref,
  input  logic [7:0]  cam_data,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  line_count,
  output logic        err_overflow,
  output logic        err_line_len,
  output logic        err_frame_len
);

  localparam logic [10:0] WIDTH_PIX    = 11'(FRAME_WIDTH);
  localparam logic [9:0]  HEIGHT_LINES = 10'(FRAME_HEIGHT);

  cap_state_t state;
  cap_state_t state_next;

  logic [1:0]         byte_phase;
  logic [PIXEL_W-1:0] pix0;
  logic [7:0]         pix1_hi;
  logic [WORD_W-1:0]  pend_word;
  logic               word_pending;
  logic [10:0]        pix_cnt;
  logic               vs_seen;
  logic               v_sync_q;
  logic               frame_started;
  logic               sof_pending;

  logic               sample;
  logic               line_end;
  logic               frame_start;
  logic               push_req;
  logic               overflow;
  logic               fifo_wr;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WORD_W-1:0]  push_word;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // A completed word is pushed one cycle after its last byte, so the h_ref
  // level seen in that cycle decides whether it closes the line.
  always_comb begin
    sample    = ((state == WAIT_LINE) || (state == CAPTURE)) && !v_sync && h_ref;
    line_end  = (state == CAPTURE) && !v_sync && !h_ref;
    push_req  = (state == CAPTURE) && !v_sync && (line_count < HEIGHT_LINES) &&
                (word_pending || (line_end && byte_phase[1]));
    push_word = word_pending ? pend_word : {{PIXEL_W{1'b0}}, pix0};
    push_entry = make_entry(sof_pending, line_end, push_word);
    pop       = out_valid && out_ready;
    overflow  = push_req && fifo_full && !pop;
    fifo_wr   = push_req && !overflow;
  end

  always_comb begin
    state_next = state;
    if (v_sync) begin
      state_next = WAIT_FRAME;
    end else begin
      case (state)
        WAIT_FRAME: if (vs_seen) state_next = WAIT_LINE;
        WAIT_LINE:  if (h_ref) state_next = CAPTURE;
        CAPTURE: begin
          if (overflow)    state_next = DROP_FRAME;
          else if (!h_ref) state_next = WAIT_LINE;
        end
        DROP_FRAME: state_next = DROP_FRAME;
        default:    state_next = WAIT_FRAME;
      endcase
    end
    frame_start = (state == WAIT_FRAME) && (state_next == WAIT_LINE);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_phase    <= '0;
      pix0          <= '0;
      pix1_hi       <= '0;
      pend_word     <= '0;
      word_pending  <= 1'b0;
      pix_cnt       <= '0;
      line_count    <= '0;
      vs_seen       <= 1'b0;
      v_sync_q      <= 1'b0;
      frame_started <= 1'b0;
      sof_pending   <= 1'b0;
      err_overflow  <= 1'b0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
    end else begin
      v_sync_q      <= v_sync;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;

      if (overflow) err_overflow <= 1'b1;

      // A frame may only start after v_sync has been seen high in WAIT_FRAME.
      if (v_sync)           vs_seen <= 1'b1;
      else if (frame_start) vs_seen <= 1'b0;

      if (frame_start) begin
        frame_started <= 1'b1;
        sof_pending   <= 1'b1;
      end else if (fifo_wr) begin
        sof_pending <= 1'b0;
      end

      if (v_sync && !v_sync_q && frame_started && (line_count != HEIGHT_LINES))
        err_frame_len <= 1'b1;

      if (v_sync) begin
        byte_phase   <= '0;
        word_pending <= 1'b0;
        pix_cnt      <= '0;
        line_count   <= '0;
      end else if (sample) begin
        byte_phase   <= byte_phase + 2'd1;
        word_pending <= (byte_phase == 2'd3);
        case (byte_phase)
          2'd0: pix0[15:8] <= cam_data;
          2'd1: pix0[7:0]  <= cam_data;
          2'd2: pix1_hi    <= cam_data;
          default: pend_word <= {pix1_hi, cam_data, pix0};
        endcase
        if (byte_phase[0] && (pix_cnt != '1)) pix_cnt <= pix_cnt + 11'd1;
      end else begin
        word_pending <= 1'b0;
        if (line_end) begin
          byte_phase   <= '0;
          pix_cnt      <= '0;
          err_line_len <= (pix_cnt != WIDTH_PIX);
          if (line_count != '1) line_count <= line_count + 10'd1;
        end
      end
    end
  end

  pixel_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (push_entry),
    .rd_en   (pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    out_valid = !fifo_empty;
    out_data  = head_entry[WORD_W-1:0];
    out_sof   = head_entry[SOF_BIT];
    out_eol   = head_entry[EOL_BIT];
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer with a word scoreboard fed by a
// byte-level model of the camera lines.
module tb_cam_pixel_packer;

  localparam int unsigned FW = 640;
  localparam int unsigned FH = 2;
  localparam int unsigned FD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_sync;
  logic        h_ref;
  logic [7:0]  cam_data;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eol;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  line_count;
  logic        err_overflow;
  logic        err_line_len;
  logic        err_frame_len;

  logic [33:0] exp_q [$];
  logic [7:0]  lb [$];
  int checks = 0;
  int errors = 0;
  int ll_pulses = 0;
  int fl_pulses = 0;
  bit exp_sof = 1'b0;
  int exp_line = 0;

  cam_pixel_packer #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .v_sync       (v_sync),
    .h_ref        (h_ref),
    .cam_data     (cam_data),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .out_eol      (out_eol),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .line_count   (line_count),
    .err_overflow (err_overflow),
    .err_line_len (err_line_len),
    .err_frame_len(err_frame_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bytes(input int n);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
  endtask

  // Expected words of one line: high byte first, pixel 2n in [15:0].
  task automatic model_line(input int max_words);
    int n;
    int nfull;
    int total;
    logic [31:0] w;
    n = lb.size();
    nfull = n / 4;
    total = nfull + (((n % 4) >= 2) ? 1 : 0);
    if (exp_line < int'(FH)) begin
      for (int k = 0; k < total && k < max_words; k++) begin
        if (k < nfull) w = {lb[4*k+2], lb[4*k+3], lb[4*k], lb[4*k+1]};
        else           w = {16'h0000, lb[4*k], lb[4*k+1]};
        exp_q.push_back({exp_sof, (k == total - 1), w});
        exp_sof = 1'b0;
      end
    end
    exp_line++;
  endtask

  task automatic drive_line(input logic tail_ready);
    for (int i = 0; i < lb.size(); i++) begin
      step();
      h_ref = 1'b1;
      cam_data = lb[i];
    end
    step();
    h_ref = 1'b0;
    cam_data = 8'h00;
    out_ready = tail_ready;
    repeat (2) step();
  endtask

  task automatic send_line(input logic tail_ready, input int max_words);
    model_line(max_words);
    drive_line(tail_ready);
  endtask

  task automatic vsync();
    step();
    v_sync = 1'b1;
    step();
    h_ref = 1'b0;
    cam_data = 8'h00;
    step();
    step();
    v_sync = 1'b0;
    step();
    step();
    exp_sof = 1'b1;
    exp_line = 0;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      step();
      c++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (err_line_len === 1'b1) ll_pulses++;
      if (err_frame_len === 1'b1) fl_pulses++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL out_word: got %0h expected no word", {out_sof, out_eol, out_data});
          end
        end else begin
          chk("out_word", {30'd0, out_sof, out_eol, out_data}, {30'd0, exp_q.pop_front()});
        end
      end else if (out_valid === 1'b1 && exp_q.size() != 0) begin
        chk("stall_hold", {30'd0, out_sof, out_eol, out_data}, {30'd0, exp_q[0]});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    v_sync = 1'b0;
    h_ref = 1'b0;
    cam_data = 8'h00;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_err_ovf", err_overflow, 0);
    chk("rst_err_ll", err_line_len, 0);
    chk("rst_err_fl", err_frame_len, 0);
    reset = 1'b0;

    // No capture until v_sync has gone high then low.
    fill_bytes(8);
    drive_line(1'b1);
    repeat (4) step();
    chk("precap_valid", out_valid, 0);

    vsync();
    chk("first_vsync_fl", 64'(fl_pulses), 0);

    // Frame A: latency and packing of a 4-byte line.
    lb.delete();
    lb.push_back(8'hA1); lb.push_back(8'hB2); lb.push_back(8'hC3); lb.push_back(8'hD4);
    model_line(1000);
    step(); h_ref = 1'b1; cam_data = 8'hA1;
    step(); cam_data = 8'hB2;
    step(); cam_data = 8'hC3;
    step(); cam_data = 8'hD4;
    step(); h_ref = 1'b0; cam_data = 8'h00;
    chk("lat_before", out_valid, 0);
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 64'hC3D4A1B2);
    chk("lat_sof", out_sof, 1);
    chk("lat_eol", out_eol, 1);
    repeat (2) step();
    chk("a0_line_count", line_count, 1);
    chk("a0_ll", 64'(ll_pulses), 1);

    fill_bytes(2 * FW);
    send_line(1'b1, 1000);
    drain(50);
    chk("a1_ll", 64'(ll_pulses), 1);
    chk("a1_line_count", line_count, 2);

    fill_bytes(8);
    send_line(1'b1, 1000);
    repeat (4) step();
    chk("a2_ll", 64'(ll_pulses), 2);
    chk("a2_line_count", line_count, 3);
    chk("a2_valid", out_valid, 0);

    vsync();
    chk("ab_fl", 64'(fl_pulses), 1);
    chk("ab_line_count", line_count, 0);

    // Frame B: flushed half word and discarded odd byte.
    fill_bytes(6);
    send_line(1'b1, 1000);
    fill_bytes(7);
    send_line(1'b1, 1000);
    drain(50);
    chk("b_ll", 64'(ll_pulses), 4);
    vsync();
    chk("bc_fl", 64'(fl_pulses), 1);

    // Frame C: push into a full FIFO on the same cycle as a pop.
    out_ready = 1'b0;
    fill_bytes(20);
    send_line(1'b1, 1000);
    drain(50);
    chk("c_err_ovf", err_overflow, 0);
    chk("c_ll", 64'(ll_pulses), 5);
    step(); h_ref = 1'b1; cam_data = 8'h5A;
    step(); cam_data = 8'h3C;
    vsync();
    chk("cd_fl", 64'(fl_pulses), 2);
    chk("cd_line_count", line_count, 0);

    // Frame D: overflow, then nothing until the next frame.
    out_ready = 1'b0;
    fill_bytes(24);
    send_line(1'b0, FD);
    chk("d_err_ovf", err_overflow, 1);
    out_ready = 1'b1;
    drain(50);
    fill_bytes(8);
    drive_line(1'b1);
    repeat (4) step();
    chk("d_drop_valid", out_valid, 0);
    chk("d_ll", 64'(ll_pulses), 5);
    vsync();
    chk("de_fl", 64'(fl_pulses), 3);

    // Frame E: recovery with sof, then reset mid-line with words buffered.
    fill_bytes(4);
    send_line(1'b1, 1000);
    drain(50);
    chk("e_ovf_sticky", err_overflow, 1);
    chk("e_ll", 64'(ll_pulses), 6);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      h_ref = 1'b1;
      cam_data = 8'($urandom);
    end
    step();
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    cam_data = 8'($urandom);
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_data", out_data, 0);
    chk("post_rst_line_count", line_count, 0);
    chk("post_rst_ovf", err_overflow, 0);
    step(); cam_data = 8'($urandom);
    step(); h_ref = 1'b0; cam_data = 8'h00;
    repeat (3) step();
    out_ready = 1'b1;
    fill_bytes(8);
    drive_line(1'b1);
    repeat (4) step();
    chk("rst_nocap_valid", out_valid, 0);
    chk("rst_nocap_ll", 64'(ll_pulses), 6);

    vsync();
    chk("f_fl", 64'(fl_pulses), 3);
    fill_bytes(4);
    send_line(1'b1, 1000);
    drain(50);
    chk("f_ll", 64'(ll_pulses), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
